// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer: holds the PLL in reset, waits for lock with timeout and retry,
// filters the synchronized lock, and gates the stream-domain reset request.
module pll_lock_sequencer #(
  parameter int unsigned RST_HOLD_CYCLES     = 16,
  parameter int unsigned LOCK_FILTER_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
  parameter int unsigned MAX_RETRIES         = 3,
  parameter int unsigned CNT_W               = 17
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic       pll_ready,
  output logic       stream_rst,
  output logic       lock_lost,
  output logic       pll_fail,
  output logic [1:0] retry_cnt,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    StResetHold = 3'd0,
    StWaitLock  = 3'd1,
    StFilter    = 3'd2,
    StReady     = 3'd3,
    StFail      = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] HoldLast    = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] FilterLast  = CNT_W'(LOCK_FILTER_CYCLES - 1);
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [1:0]       RetryMax    = 2'(MAX_RETRIES);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       retry_q, retry_d;
  logic             sync1_q, locked_s;
  logic             pll_rst_q, pll_ready_q, stream_rst_q, lock_lost_q, pll_fail_q;
  logic             lock_lost_d;

  // pll_locked is asynchronous to refclk; only locked_s is used below.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      sync1_q  <= pll_locked;
      locked_s <= sync1_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    retry_d     = retry_q;
    lock_lost_d = 1'b0;
    if (relock_req) begin
      state_d = StResetHold;
      cnt_d   = '0;
      retry_d = '0;
    end else begin
      unique case (state_q)
        StResetHold: begin
          if (cnt_q == HoldLast) begin
            state_d = StWaitLock;
            cnt_d   = '0;
          end
        end
        StWaitLock: begin
          // Lock beats a coincident timeout.
          if (locked_s) begin
            state_d = StFilter;
            cnt_d   = '0;
          end else if (cnt_q == TimeoutLast) begin
            cnt_d = '0;
            if (retry_q == RetryMax) begin
              state_d = StFail;
            end else begin
              state_d = StResetHold;
              retry_d = retry_q + 2'd1;
            end
          end
        end
        StFilter: begin
          if (!locked_s) begin
            state_d = StWaitLock;
            cnt_d   = '0;
          end else if (cnt_q == FilterLast) begin
            state_d = StReady;
            cnt_d   = '0;
            retry_d = '0;
          end
        end
        StReady: begin
          cnt_d = '0;
          if (!locked_s) begin
            state_d     = StResetHold;
            lock_lost_d = 1'b1;
          end
        end
        StFail: begin
          cnt_d = '0;
        end
        default: begin
          state_d = StResetHold;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they move with the state register.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q      <= StResetHold;
      cnt_q        <= '0;
      retry_q      <= '0;
      pll_rst_q    <= 1'b1;
      stream_rst_q <= 1'b1;
      pll_ready_q  <= 1'b0;
      lock_lost_q  <= 1'b0;
      pll_fail_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      pll_rst_q    <= (state_d == StResetHold) || (state_d == StFail);
      stream_rst_q <= (state_d != StReady);
      pll_ready_q  <= (state_d == StReady);
      lock_lost_q  <= lock_lost_d;
      pll_fail_q   <= (state_d == StFail);
    end
  end

  assign pll_rst    = pll_rst_q;
  assign pll_ready  = pll_ready_q;
  assign stream_rst = stream_rst_q;
  assign lock_lost  = lock_lost_q;
  assign pll_fail   = pll_fail_q;
  assign retry_cnt  = retry_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer: expected output vectors are queued per step and
// compared one cycle-step later, 1 time unit after the refclk edge.
module tb_pll_lock_sequencer;

  logic       refclk = 1'b0;
  logic       rst = 1'b0;
  logic       pll_locked = 1'b0;
  logic       relock_req = 1'b0;
  logic       pll_rst, pll_ready, stream_rst, lock_lost, pll_fail;
  logic [1:0] retry_cnt;
  logic [2:0] state_o;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string      tag;
    logic [9:0] exp;
  } sb_t;
  sb_t sb_q[$];

  localparam logic [2:0] RH = 3'd0, WL = 3'd1, FI = 3'd2, RD = 3'd3, FL = 3'd4;

  pll_lock_sequencer #(
    .RST_HOLD_CYCLES    (4),
    .LOCK_FILTER_CYCLES (8),
    .LOCK_TIMEOUT_CYCLES(32),
    .MAX_RETRIES        (2),
    .CNT_W              (17)
  ) dut (
    .refclk    (refclk),
    .rst       (rst),
    .pll_locked(pll_locked),
    .relock_req(relock_req),
    .pll_rst   (pll_rst),
    .pll_ready (pll_ready),
    .stream_rst(stream_rst),
    .lock_lost (lock_lost),
    .pll_fail  (pll_fail),
    .retry_cnt (retry_cnt),
    .state_o   (state_o)
  );

  always #5 refclk = ~refclk;

  // Vector layout: {state, retry, fail, lost, stream_rst, ready, pll_rst}
  function automatic logic [9:0] exp_vec(logic [2:0] st, logic [1:0] r, logic lost);
    logic fail, srst, rdy, prst;
    fail = (st == FL);
    srst = (st != RD);
    rdy  = (st == RD);
    prst = (st == RH) || (st == FL);
    return {st, r, fail, lost, srst, rdy, prst};
  endfunction

  task automatic check_out();
    sb_t        e;
    logic [9:0] obs;
    while (sb_q.size() > 0) begin
      e   = sb_q.pop_front();
      obs = {state_o, retry_cnt, pll_fail, lock_lost, stream_rst, pll_ready, pll_rst};
      n_checks++;
      assert (obs === e.exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed=%b required=%b", e.tag, obs, e.exp);
      end
    end
  endtask

  // Queue the expectation, advance n refclk edges, then compare 1 unit after the edge.
  task automatic go(int n, string tag, logic [2:0] st, logic [1:0] r, logic lost);
    sb_t e;
    e.tag = tag;
    e.exp = exp_vec(st, r, lost);
    sb_q.push_back(e);
    repeat (n) @(posedge refclk);
    #1;
    check_out();
  endtask

  initial begin
    #1 rst = 1'b1;
    go(0, "reset", RH, 2'd0, 1'b0);
    @(negedge refclk) rst = 1'b0;

    // Clean bring-up
    go(3, "hold_e3", RH, 2'd0, 1'b0);
    go(1, "pllrst_fall_e4", WL, 2'd0, 1'b0);
    go(6, "wait_e10", WL, 2'd0, 1'b0);
    pll_locked = 1'b1;
    go(2, "sync_e12", WL, 2'd0, 1'b0);
    go(1, "filter_e13", FI, 2'd0, 1'b0);
    go(7, "filter_e20", FI, 2'd0, 1'b0);
    go(1, "ready_e21", RD, 2'd0, 1'b0);

    // Lock loss in READY
    pll_locked = 1'b0;
    go(2, "ready_e23", RD, 2'd0, 1'b0);
    go(1, "lost_pulse", RH, 2'd0, 1'b1);
    go(1, "lost_clear", RH, 2'd0, 1'b0);
    go(2, "relost_hold", RH, 2'd0, 1'b0);
    go(1, "relost_wait", WL, 2'd0, 1'b0);

    // Re-lock with a one-cycle glitch during FILTER
    pll_locked = 1'b1;
    go(3, "glitch_filter", FI, 2'd0, 1'b0);
    go(3, "glitch_filter5", FI, 2'd0, 1'b0);
    pll_locked = 1'b0;
    go(1, "glitch_low", FI, 2'd0, 1'b0);
    pll_locked = 1'b1;
    go(1, "glitch_pre", FI, 2'd0, 1'b0);
    go(1, "glitch_wait", WL, 2'd0, 1'b0);
    go(1, "glitch_refilter", FI, 2'd0, 1'b0);
    go(7, "glitch_filter7", FI, 2'd0, 1'b0);
    go(1, "glitch_ready", RD, 2'd0, 1'b0);

    // relock_req coincident with lock loss in READY: no lock_lost
    pll_locked = 1'b0;
    go(2, "ready_pre_relock", RD, 2'd0, 1'b0);
    relock_req = 1'b1;
    go(1, "relock_ready", RH, 2'd0, 1'b0);
    relock_req = 1'b0;
    go(3, "reseq_hold", RH, 2'd0, 1'b0);
    go(1, "reseq_wait", WL, 2'd0, 1'b0);

    // Timeouts, retries and FAIL
    go(31, "to1_pre", WL, 2'd0, 1'b0);
    go(1, "to1", RH, 2'd1, 1'b0);
    go(4, "wait_r1", WL, 2'd1, 1'b0);
    go(31, "to2_pre", WL, 2'd1, 1'b0);
    go(1, "to2", RH, 2'd2, 1'b0);
    go(4, "wait_r2", WL, 2'd2, 1'b0);
    go(31, "to3_pre", WL, 2'd2, 1'b0);
    go(1, "fail_entry", FL, 2'd2, 1'b0);
    for (int i = 0; i < 100; i++) go(1, "fail_sticky", FL, 2'd2, 1'b0);

    // relock_req in FAIL
    relock_req = 1'b1;
    go(1, "relock_fail", RH, 2'd0, 1'b0);
    relock_req = 1'b0;
    pll_locked = 1'b1;
    go(3, "hold_ignores_lock", RH, 2'd0, 1'b0);
    go(1, "relock_wait", WL, 2'd0, 1'b0);
    go(1, "relock_filter", FI, 2'd0, 1'b0);
    go(2, "mid_filter", FI, 2'd0, 1'b0);

    // Asynchronous reset between edges
    #3 rst = 1'b1;
    go(0, "async_reset", RH, 2'd0, 1'b0);
    @(negedge refclk) rst = 1'b0;
    go(4, "post_rst_wait", WL, 2'd0, 1'b0);
    go(1, "post_rst_filter", FI, 2'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
- Sequences reset and lock qualification for the stream PLL: 50 MHz refclk in; 108 MHz and 154.29 MHz outputs; pll_rst in; locked out.
- Runs on the free-running refclk and holds the PLL in reset for a minimum pulse, then waits for lock with a timeout and filters the locked signal.
- Releases a downstream stream-domain reset request only after lock is stable, and retries on timeout or lock loss.
- Exposes ready/fail status to the HPS CSR block and accepts a software relock request.

Parameters:
- RST_HOLD_CYCLES, 16, refclk cycles that pll_rst is held high per attempt (min 1).
- LOCK_FILTER_CYCLES, 1024, consecutive synchronized-locked cycles required before ready (min 1).
- LOCK_TIMEOUT_CYCLES, 50000, refclk cycles allowed in WAIT_LOCK before a retry (1 ms).
- MAX_RETRIES, 3, timeouts tolerated before FAIL; retry_cnt width is 2 bits and MAX_RETRIES must be ≤3.
- CNT_W, 17, shared cycle-counter width; must hold max(RST_HOLD, FILTER, TIMEOUT)-1.

Ports:
- refclk  in  1  50 MHz free-running clock; same source as the PLL reference.
- rst  in  1  asynchronous, active-high reset.
- pll_locked  in  1  PLL locked; asynchronous to refclk; synchronized internally through 2 flops.
- relock_req  in  1  single-cycle software pulse; forces a full re-sequence.
- pll_rst  out  1  reset to the PLL.
- pll_ready  out  1  lock qualified; PLL outputs usable.
- stream_rst  out  1  active-high reset request to the stream domains; downstream synchronizes it per clock.
- lock_lost  out  1  one-cycle pulse when lock drops while READY.
- pll_fail  out  1  sticky; retries exhausted.
- retry_cnt  out  2  timeouts in the current sequence.
- state_o  out  3  encoded state: RESET_HOLD=0, WAIT_LOCK=1, FILTER=2, READY=3, FAIL=4.

Behaviour:
- Reset values:
  - Asserting rst sets state=RESET_HOLD, cnt=0, sync flops=0.
  - Output reset values: pll_rst=1, stream_rst=1, pll_ready=0, lock_lost=0, pll_fail=0, retry_cnt=0.
  - Reset mid-operation aborts immediately to these values.
- All outputs are registered, decoded from the next state, so they change on the same edge as the state register.
- locked_s is the 2-flop synchronized pll_locked; it is the only form of lock the FSM sees.
- One shared counter cnt is cleared on every state transition.
- RESET_HOLD:
  - Outputs: pll_rst=1, stream_rst=1, pll_ready=0.
  - When cnt==RST_HOLD_CYCLES-1, go to WAIT_LOCK; otherwise cnt++.
  - locked_s is ignored in this state.
- WAIT_LOCK:
  - Outputs: pll_rst=0, stream_rst=1.
  - If locked_s=1, go to FILTER.
  - Else if cnt==LOCK_TIMEOUT_CYCLES-1: if retry_cnt==MAX_RETRIES go to FAIL; otherwise retry_cnt++ and go to RESET_HOLD.
  - Otherwise cnt++.
- FILTER:
  - Outputs: pll_rst=0, stream_rst=1.
  - If locked_s=0, go to WAIT_LOCK; the timeout window restarts at 0 and retry_cnt is unchanged.
  - Else if cnt==LOCK_FILTER_CYCLES-1, go to READY; otherwise cnt++.
- READY:
  - Outputs: pll_ready=1, stream_rst=0, pll_rst=0; retry_cnt is cleared on entry.
  - If locked_s=0: lock_lost=1 for exactly one cycle (the transition edge), then go to RESET_HOLD; pll_ready and stream_rst change on that same edge.
- FAIL:
  - Outputs: pll_rst=1, stream_rst=1, pll_ready=0, pll_fail=1.
  - Held until relock_req.
- relock_req:
  - Highest priority in every state.
  - Next state is RESET_HOLD with cnt=0, retry_cnt=0 and pll_fail cleared.
  - lock_lost is NOT pulsed.
- Simultaneous events:
  - relock_req and lock loss in READY: relock wins, no lock_lost.
  - Timeout and locked_s rising on the same cycle in WAIT_LOCK: lock wins, go to FILTER.
- Latency:
  - pll_rst falls on the RST_HOLD_CYCLES-th refclk edge after rst deassertion.
  - pll_ready rises LOCK_FILTER_CYCLES+3 edges after pll_locked rises, assuming it stays high: 2 sync edges + 1 detect edge + filter.
- Glitch rejection: lock glitches shorter than LOCK_FILTER_CYCLES during FILTER never produce pll_ready.

Test Plan:
Bench parameters for all scenarios: RST_HOLD=4, FILTER=8, TIMEOUT=32, MAX_RETRIES=2.
1. Clean bring-up: release rst, raise pll_locked at edge 10 → pll_rst falls at edge 4; pll_ready=1 and stream_rst=0 from edge 21; retry_cnt=0.
2. Glitch filter: in FILTER, drop pll_locked for 1 cycle after 5 high cycles → state returns to WAIT_LOCK; pll_ready only after 8 further consecutive high cycles.
3. Timeout/retry/fail: hold pll_locked=0 → retry_cnt steps 1, 2; after the third timeout state_o=4, pll_fail=1, pll_rst=1; pll_fail remains 1 for 100 cycles.
4. Lock loss: in READY, drop pll_locked → lock_lost high exactly 1 cycle, 3 edges after the drop; pll_ready=0; pll_rst=1 for 4 cycles; normal re-lock follows.
5. relock_req: pulse in FAIL → pll_fail=0, retry_cnt=0, state RESET_HOLD. Pulse in READY → no lock_lost; full re-sequence.
6. Async reset mid-FILTER: assert rst between edges → outputs return to reset values immediately, without waiting for an edge.
